// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : 5-stage pipeline stall/flush controller (memory wait, branch
//            flush, load-use) with saturating stall counter and sticky timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazardflag,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_timeout = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEMWAIT  = 2'b01,
        LU_STALL = 2'b10,
        FLUSH    = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_mem_wait;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_count;
    logic              r_mem_timeout;

    // mem_ready is meaningful only alongside an outstanding request
    assign w_mem_wait = mem_req & ~mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = RUN;
        pcwrite      = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        if (w_mem_wait) begin
            pcwrite      = 1'b0;
            ifid_write   = 1'b0;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
            w_next_state = MEMWAIT;
        end else if (branch_taken) begin
            // flush wins over the IF/ID load; ifid_write stays at its default
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            w_next_state = FLUSH;
        end else if (hazardflag && (r_state == RUN)) begin
            pcwrite      = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            w_next_state = LU_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (!pcwrite && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    // Counter restarts when a wait begins and counts only cycles spent in MEMWAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_mem_wait) begin
            if (r_state != MEMWAIT) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_timeout) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                if ((r_wait_cnt + WAIT_W'(1)) == c_timeout) begin
                    r_mem_timeout <= 1'b1;
                end
            end
        end
    end

    assign state       = r_state;
    assign stall_count = r_stall_count;
    assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire
